framebuffer_scanout: RTL and testbench

Reader end of the 160x120, 3-bit-colour pixel framebuffer that the drawing datapath fills. The block generates 640x480@60 VGA timing from a 25 MHz pixel clock and reads the framebuffer through a synchronous-read port. It scales each stored pixel 4x4 and drives the DAC RGB and sync pins. It also reports vertical blanking so the drawing FSM can schedule screen redraws without tearing.

---
 rtl/framebuffer_scanout.sv | 112 +++++++++++
 tb/tb_framebuffer_scanout.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout.sv
// VGA scan-out for a 160x120 3-bit framebuffer: 640x480@60 timing, 4x4 pixel
// replication, synchronous-read framebuffer port and a vblank hint for the drawer.
module framebuffer_scanout #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [14:0] mem_addr,
   input  logic [2:0]  mem_data,
   input  logic        force_black,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        vblank,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned CW      = 4 * (MEM_LAT + 1);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          hsRaw;
   logic          vsRaw;
   logic          active;
   logic [14:0]   fx;
   logic [14:0]   fy;
   logic [14:0]   nextAddr;
   logic [3:0]    ctrlNow;
   logic [CW-1:0] ctrlSr;
   logic [3:0]    ctrlTail;
   logic          pixOn;

   assign vga_sync_n = 1'b0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         h <= '0;
         v <= '0;
      end else if (h == HW'(H_TOTAL - 1)) begin
         h <= '0;
         v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   // fy*160 built from two shifts so no multiplier is inferred
   always_comb begin
      hsRaw    = !((h >= HW'(H_VISIBLE + H_FRONT)) && (h < HW'(H_VISIBLE + H_FRONT + H_SYNC)));
      vsRaw    = !((v >= VW'(V_VISIBLE + V_FRONT)) && (v < VW'(V_VISIBLE + V_FRONT + V_SYNC)));
      active   = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
      fx       = 15'(h >> 2);
      fy       = 15'(v >> 2);
      nextAddr = (fy << 7) + (fy << 5) + fx;
      ctrlNow  = {hsRaw, vsRaw, active, force_black};
   end

   assign ctrlTail = ctrlSr[CW-1 -: 4];
   assign pixOn    = ctrlTail[1] && !ctrlTail[0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_addr    <= '0;
         ctrlSr      <= '0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (active) begin
            mem_addr <= nextAddr;
         end
         ctrlSr      <= {ctrlSr[CW-5:0], ctrlNow};
         vblank      <= (v >= VW'(V_VISIBLE));
         frame_start <= (h == '0) && (v == VW'(V_VISIBLE));
      end
   end

   // control bits travel 1+MEM_LAT stages so they meet the matching mem_data here
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         vga_r       <= {8{pixOn && mem_data[2]}};
         vga_g       <= {8{pixOn && mem_data[1]}};
         vga_b       <= {8{pixOn && mem_data[0]}};
         vga_hs      <= ctrlTail[3];
         vga_vs      <= ctrlTail[2];
         vga_blank_n <= ctrlTail[1];
      end
   end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: a position-from-cycle-count model
// queues expected outputs, a monitor pops and compares them every clock.
module tb_framebuffer_scanout;

   localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48;
   localparam int unsigned VV = 16, VF = 2, VS = 2, VB = 2;
   localparam int unsigned HT = HV + HF + HS + HB;
   localparam int unsigned VT = VV + VF + VS + VB;
   localparam int unsigned FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        force_black = 1'b0;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vblank, frame_start;

   logic [2:0]  mem [0:32767];
   logic [27:0] pixQ[$];
   logic [16:0] stgQ[$];

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned n = 0;
   int unsigned lastAddr = 0;
   int unsigned mCyc = 0;
   int unsigned fsCycle = 0;
   bit          fsSeen = 1'b0;

   always #20 clk = ~clk;

   framebuffer_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .MEM_LAT(1)
   ) dut (
      .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_data(mem_data),
      .force_black(force_black), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vblank(vblank), .frame_start(frame_start)
   );

   // one-cycle synchronous-read framebuffer
   always @(posedge clk) mem_data <= mem[mem_addr];

   task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, mCyc, got, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      check({tag, " pins"}, {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n},
            {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0});
      check({tag, " mem_addr"}, 28'(mem_addr), 28'h0);
      check({tag, " vblank/frame_start"}, 28'({vblank, frame_start}), 28'h0);
   endtask

   // expected behaviour of screen position n, derived from raster arithmetic
   task automatic pushCycle();
      int unsigned p, h, v, a;
      logic fb, act, on, hs, vs;
      logic [2:0] c;
      logic [7:0] r, g, b;
      fb = ($urandom_range(7) == 0);
      force_black = fb;
      p = n % FRAME;
      h = p % HT;
      v = p / HT;
      act = (h < HV) && (v < VV);
      a = (v / 4) * 160 + h / 4;
      c = act ? mem[15'(a)] : 3'b000;
      on = act && !fb;
      r = (on && c[2]) ? 8'hFF : 8'h00;
      g = (on && c[1]) ? 8'hFF : 8'h00;
      b = (on && c[0]) ? 8'hFF : 8'h00;
      hs = !((h >= HV + HF) && (h < HV + HF + HS));
      vs = !((v >= VV + VF) && (v < VV + VF + VS));
      pixQ.push_back({r, g, b, hs, vs, act, 1'b0});
      if (act) lastAddr = a;
      stgQ.push_back({15'(lastAddr), (v >= VV), (h == 0) && (v == VV)});
      n++;
   endtask

   task automatic step();
      @(negedge clk);
      pushCycle();
   endtask

   task automatic releaseReset();
      @(negedge clk);
      resetn = 1'b1;
      n = 0;
      lastAddr = 0;
      pushCycle();
   endtask

   // monitor: address/vblank lag the raster by 1 clock, pixel pins by 3
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!resetn) begin
            mCyc = 0;
            fsSeen = 1'b0;
            fsCycle = 0;
         end else begin
            mCyc++;
            if (frame_start && !fsSeen) begin
               fsSeen = 1'b1;
               fsCycle = mCyc;
            end
            if (stgQ.size() >= 1)
               check("addr/vblank", 28'({mem_addr, vblank, frame_start}), 28'(stgQ.pop_front()));
            if (pixQ.size() >= 3)
               check("pixel pins", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n},
                     pixQ.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
      mem[5] = 3'b101;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkReset("power-on reset");

      releaseReset();
      while (n < FRAME + 10 * HT + 300) step();
      check("first frame_start cycle", 28'(fsCycle), 28'(VV * HT + 1));

      @(negedge clk);
      resetn = 1'b0;
      force_black = 1'b0;
      #1;
      checkReset("mid-frame reset");
      pixQ.delete();
      stgQ.delete();
      repeat (2) @(negedge clk);

      releaseReset();
      for (int i = 0; i < int'(VV * HT + 100) && !fsSeen; i++) step();
      check("frame_start after restart", 28'(fsCycle), 28'(VV * HT + 1));
      repeat (50) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
